// File: rtl/tmr_pkg.sv
// Shared types and helpers for the TMR fault monitor: FSM states, lane index,
// sample classification of voter ERROR flags.
package tmr_pkg;

  localparam int unsigned NUM_LANES = 3;

  typedef enum logic [1:0] {IDLE, SUSPECT, REPAIR} fsm_state_t;
  typedef enum logic [1:0] {CLEAN, SINGLE, MULTI} sample_class_t;
  typedef logic [1:0] lane_t;

  function automatic sample_class_t classify(input logic [2:0] e);
    logic [1:0] pop;
    pop = {1'b0, e[0]} + {1'b0, e[1]} + {1'b0, e[2]};
    if (pop == 2'd0)      return CLEAN;
    else if (pop == 2'd1) return SINGLE;
    else                  return MULTI;
  endfunction

  // Only meaningful when exactly one flag is set.
  function automatic lane_t lane_of(input logic [2:0] e);
    if (e[2])      return lane_t'(2);
    else if (e[1]) return lane_t'(1);
    else           return lane_t'(0);
  endfunction

endpackage

// File: rtl/tmr_sat_counter.sv
// Saturating up-counter with synchronous clear; clear takes priority over increment.
module tmr_sat_counter #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)                    count <= '0;
    else if (clr)                   count <= '0;
    else if (inc && (count != '1))  count <= count + 1'b1;
  end

endmodule

// File: rtl/tmr_fault_monitor.sv
// Per-lane error statistics and persistent-fault repair requests behind a TMR voter.
// Optional irq output enabled by defining TMR_FAULT_IRQ_EN.
module tmr_fault_monitor
  import tmr_pkg::*;
#(
  parameter int unsigned N       = 32,
  parameter int unsigned CNT_W   = 8,
  parameter int unsigned PERSIST = 4
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               err_valid,
  input  logic [2:0]         err_in,
  input  logic [N-1:0]       voted_in,
  input  logic               clear,
  output logic [3*CNT_W-1:0] err_cnt,
  output logic [2:0]         faulted,
  output logic               uncorrectable,
  output logic               repair_req,
  output logic [1:0]         repair_lane,
  output logic [N-1:0]       repair_data,
  input  logic               repair_ack
`ifdef TMR_FAULT_IRQ_EN
  , output logic             irq
`endif
);

  localparam int unsigned RUN_W = $clog2(PERSIST + 1);
  localparam logic [RUN_W-1:0] PERSIST_M1 = RUN_W'(PERSIST - 1);

  fsm_state_t    state;
  lane_t         lane;
  logic [RUN_W-1:0] run;

  sample_class_t cls;
  lane_t         lane_in;
  logic          single, multi, enter_repair;
  logic [2:0]    faulted_nxt;
  logic          unc_nxt;

  assign cls     = classify(err_in);
  assign lane_in = lane_of(err_in);
  assign single  = err_valid && (cls == SINGLE);
  assign multi   = err_valid && (cls == MULTI);

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_cnt
    tmr_sat_counter #(.W(CNT_W)) u_cnt (
      .clk    (clk),
      .resetn (resetn),
      .inc    (single && (lane_in == lane_t'(g))),
      .clr    (clear),
      .count  (err_cnt[g*CNT_W +: CNT_W])
    );
  end

  // Clear pulls the FSM back to IDLE outside REPAIR, so it also blocks fault entry.
  always_comb begin
    enter_repair = 1'b0;
    if (single && !clear) begin
      if (state == IDLE && PERSIST == 1) enter_repair = 1'b1;
      if (state == SUSPECT && lane_in == lane && run == PERSIST_M1) enter_repair = 1'b1;
    end
    faulted_nxt = clear ? 3'b000 : (faulted | (enter_repair ? (3'b001 << lane_in) : 3'b000));
    unc_nxt     = clear ? 1'b0 : (uncorrectable | multi);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      faulted       <= '0;
      uncorrectable <= 1'b0;
    end else begin
      faulted       <= faulted_nxt;
      uncorrectable <= unc_nxt;
    end
  end

`ifdef TMR_FAULT_IRQ_EN
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) irq <= 1'b0;
    else         irq <= !clear && ((|(faulted_nxt & ~faulted)) || (unc_nxt && !uncorrectable));
  end
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state       <= IDLE;
      lane        <= '0;
      run         <= '0;
      repair_req  <= 1'b0;
      repair_lane <= '0;
      repair_data <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (single && !clear) begin
            lane <= lane_in;
            run  <= RUN_W'(1);
            if (enter_repair) begin
              state       <= REPAIR;
              repair_req  <= 1'b1;
              repair_lane <= lane_in;
              repair_data <= voted_in;
            end else begin
              state <= SUSPECT;
            end
          end
        end
        SUSPECT: begin
          if (clear) begin
            state <= IDLE;
          end else if (err_valid) begin
            if (!single) begin
              state <= IDLE;
            end else if (lane_in != lane) begin
              lane <= lane_in;
              run  <= RUN_W'(1);
            end else if (enter_repair) begin
              state       <= REPAIR;
              repair_req  <= 1'b1;
              repair_lane <= lane_in;
              repair_data <= voted_in;
            end else begin
              run <= run + 1'b1;
            end
          end
        end
        REPAIR: begin
          if (repair_ack) begin
            state      <= IDLE;
            repair_req <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
